// File: rtl/txn_log_pkg.sv
// Shared constants, state encoding and hex helper for the transaction log formatter.
package txn_log_pkg;

    localparam int REC_LEN     = 12;
    localparam int ALPHA_RADIX = 26;

    localparam logic [7:0] ASC_NL   = 8'h0a;
    localparam logic [7:0] ASC_SP   = 8'h20;
    localparam logic [7:0] ASC_SEMI = 8'h3b;
    localparam logic [7:0] ASC_W    = 8'h57;
    localparam logic [7:0] ASC_R    = 8'h52;
    localparam logic [7:0] ASC_QM   = 8'h3f;
    localparam logic [7:0] ASC_A    = 8'h61;
    localparam logic [7:0] ASC_0    = 8'h30;

    typedef enum logic [2:0] {
        IDLE,
        DIVIDE,
        WRAP,
        EMIT,
        FLUSH
    } state_t;

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASC_0 + {4'h0, n};
        end
        return ASC_A + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/txn_log_formatter_alpha_div26.sv
// Iterative subtract-26 divider: splits a transaction ID into the two-letter code digits j and k.
module alpha_div26
    import txn_log_pkg::*;
#(
    parameter int ID_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ID_W-1:0] id,
    output logic            done,
    output logic [ID_W-1:0] j,
    output logic [4:0]      k
);

    localparam logic [ID_W-1:0] DIVISOR = ID_W'(ALPHA_RADIX);

    logic [ID_W-1:0] rem;
    logic            busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
        end else if (busy && rem < DIVISOR) begin
            busy <= 1'b0;
        end
    end

    // Quotient and remainder hold after completion so the emitter can keep reading them.
    always_ff @(posedge clk) begin
        if (start) begin
            rem <= id;
            j   <= '0;
        end else if (busy && rem >= DIVISOR) begin
            rem <= rem - DIVISOR;
            j   <= j + 1'b1;
        end
    end

    assign done = busy && (rem < DIVISOR);
    assign k    = rem[4:0];

endmodule

// File: rtl/txn_log_formatter.sv
// Formats monitored I2C transfer records into a line-wrapped ASCII character stream.
module txn_log_formatter
    import txn_log_pkg::*;
#(
    parameter int LINE_LEN = 76,
    parameter int ID_W     = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            txn_valid_i,
    output logic            txn_ready_o,
    input  logic [ID_W-1:0] txn_id_i,
    input  logic            txn_op_i,
    input  logic [6:0]      txn_addr_i,
    input  logic [7:0]      txn_data_i,
    input  logic            flush_i,
    output logic            ch_valid_o,
    input  logic            ch_ready_i,
    output logic [7:0]      ch_data_o,
    output logic [6:0]      col_o,
    output logic [15:0]     rec_cnt_o
);

    generate
        if (LINE_LEN < REC_LEN) begin : g_len_chk
            $error("txn_log_formatter: LINE_LEN must be at least REC_LEN");
        end
    endgenerate

    state_t          state;
    logic            flush_pend;
    logic [3:0]      idx;
    logic [6:0]      col;
    logic [15:0]     rec_cnt;
    logic            op_r;
    logic [6:0]      addr_r;
    logic [7:0]      data_r;
    logic            accept;
    logic            hs;
    logic            wrap_needed;
    logic            div_done;
    logic [ID_W-1:0] div_j;
    logic [4:0]      div_k;

    assign txn_ready_o = (state == IDLE) && !flush_pend && !rst_i;
    assign accept      = txn_valid_i && txn_ready_o;
    assign hs          = ch_valid_o && ch_ready_i;
    assign wrap_needed = (int'(col) + REC_LEN) > LINE_LEN;
    assign col_o       = col;
    assign rec_cnt_o   = rec_cnt;

    function automatic logic [7:0] rec_char(
        input logic [3:0]      i,
        input logic [ID_W-1:0] j,
        input logic [4:0]      k,
        input logic            op,
        input logic [6:0]      addr,
        input logic [7:0]      data
    );
        case (i)
            4'd0:    return (j <= ID_W'(25)) ? ASC_A + 8'(j) : ASC_QM;
            4'd1:    return ASC_A + {3'b000, k};
            4'd3:    return op ? ASC_W : ASC_R;
            4'd5:    return nibble_to_hex({1'b0, addr[6:4]});
            4'd6:    return nibble_to_hex(addr[3:0]);
            4'd8:    return nibble_to_hex(data[7:4]);
            4'd9:    return nibble_to_hex(data[3:0]);
            4'd10:   return ASC_SEMI;
            default: return ASC_SP;
        endcase
    endfunction

    alpha_div26 #(.ID_W(ID_W)) u_div (
        .clk   (clk_i),
        .rst   (rst_i),
        .start (accept),
        .id    (txn_id_i),
        .done  (div_done),
        .j     (div_j),
        .k     (div_k)
    );

    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_r   <= txn_op_i;
            addr_r <= txn_addr_i;
            data_r <= txn_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            col        <= '0;
            rec_cnt    <= '0;
            ch_valid_o <= 1'b0;
            ch_data_o  <= 8'h00;
            flush_pend <= 1'b0;
            idx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_pend) begin
                        if (col != '0) begin
                            state      <= FLUSH;
                            ch_valid_o <= 1'b1;
                            ch_data_o  <= ASC_NL;
                        end else begin
                            flush_pend <= 1'b0;
                        end
                    end else if (accept) begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        idx        <= '0;
                        ch_valid_o <= 1'b1;
                        if (wrap_needed) begin
                            state     <= WRAP;
                            ch_data_o <= ASC_NL;
                        end else begin
                            state     <= EMIT;
                            ch_data_o <= rec_char(4'd0, div_j, div_k, op_r, addr_r, data_r);
                        end
                    end
                end
                WRAP: begin
                    if (hs) begin
                        col       <= '0;
                        state     <= EMIT;
                        ch_data_o <= rec_char(4'd0, div_j, div_k, op_r, addr_r, data_r);
                    end
                end
                EMIT: begin
                    if (hs) begin
                        if (idx == 4'(REC_LEN - 1)) begin
                            ch_valid_o <= 1'b0;
                            col        <= col + 7'(REC_LEN);
                            rec_cnt    <= rec_cnt + 16'd1;
                            state      <= IDLE;
                        end else begin
                            idx       <= idx + 4'd1;
                            ch_data_o <= rec_char(idx + 4'd1, div_j, div_k, op_r, addr_r, data_r);
                        end
                    end
                end
                FLUSH: begin
                    if (hs) begin
                        ch_valid_o <= 1'b0;
                        col        <= '0;
                        flush_pend <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new request always wins over any clear made above in the same cycle.
            if (flush_i) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_txn_log_formatter.sv
// Bench for txn_log_formatter: directed and random records checked against a text-level model.
module tb_txn_log_formatter;

    localparam int LINE_LEN = 76;
    localparam int ID_W     = 10;

    logic            clk;
    logic            rst_i;
    logic            txn_valid_i;
    logic            txn_ready_o;
    logic [ID_W-1:0] txn_id_i;
    logic            txn_op_i;
    logic [6:0]      txn_addr_i;
    logic [7:0]      txn_data_i;
    logic            flush_i;
    logic            ch_valid_o;
    logic            ch_ready_i;
    logic [7:0]      ch_data_o;
    logic [6:0]      col_o;
    logic [15:0]     rec_cnt_o;

    logic            rand_mode;
    logic            ready_force;
    logic            rnd_bit;

    logic [7:0]      got[$];
    logic [7:0]      exp[$];
    int              mcol;
    int              mrec;
    int              errors;
    int              checks;

    txn_log_formatter #(.LINE_LEN(LINE_LEN), .ID_W(ID_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .txn_valid_i (txn_valid_i),
        .txn_ready_o (txn_ready_o),
        .txn_id_i    (txn_id_i),
        .txn_op_i    (txn_op_i),
        .txn_addr_i  (txn_addr_i),
        .txn_data_i  (txn_data_i),
        .flush_i     (flush_i),
        .ch_valid_o  (ch_valid_o),
        .ch_ready_i  (ch_ready_i),
        .ch_data_o   (ch_data_o),
        .col_o       (col_o),
        .rec_cnt_o   (rec_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ch_ready_i = rand_mode ? rnd_bit : ready_force;

    initial rnd_bit = 1'b1;
    always @(negedge clk) rnd_bit = ($urandom_range(0, 3) != 0);

    // Every accepted character, in order, as the sink sees it.
    always @(posedge clk) begin
        if (!rst_i && ch_valid_o && ch_ready_i) got.push_back(ch_data_o);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Reference text of one record, straight from the two-letter code and hex rules.
    function automatic string rec_str(input int id, input bit op, input int addr, input int data);
        int j = id / 26;
        int k = id % 26;
        logic [7:0] jc = (j <= 25) ? 8'(8'h61 + j) : 8'h3f;
        logic [7:0] kc = 8'(8'h61 + k);
        logic [7:0] oc = op ? 8'h57 : 8'h52;
        logic [7:0] a8 = 8'(addr);
        logic [7:0] d8 = 8'(data);
        return $sformatf("%c%c %c %02h %02h; ", jc, kc, oc, a8, d8);
    endfunction

    task automatic model_rec(input int id, input bit op, input int addr, input int data);
        string s = rec_str(id, op, addr, data);
        if (mcol + 12 > LINE_LEN) begin
            exp.push_back(8'h0a);
            mcol = 0;
        end
        for (int i = 0; i < s.len(); i++) exp.push_back(s[i]);
        mcol += 12;
        mrec = (mrec + 1) % 65536;
    endtask

    task automatic model_flush();
        if (mcol > 0) begin
            exp.push_back(8'h0a);
            mcol = 0;
        end
    endtask

    // Presents one record, optionally with flush_i on the accept cycle, and checks divide latency.
    task automatic send(input int id, input bit op, input int addr, input int data, input bit fl);
        int n = 0;
        int lat = 0;
        txn_valid_i = 1'b1;
        txn_id_i    = ID_W'(id);
        txn_op_i    = op;
        txn_addr_i  = 7'(addr);
        txn_data_i  = 8'(data);
        while (!txn_ready_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", txn_ready_o, 1'b1);
        flush_i = fl;
        @(posedge clk);
        #1;
        txn_valid_i = 1'b0;
        flush_i     = 1'b0;
        model_rec(id, op, addr, data);
        if (fl) model_flush();
        @(negedge clk);
        while (!ch_valid_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("divide_latency_id%0d", id), lat, id / 26 + 1);
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        model_flush();
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(got.size() >= exp.size() && !ch_valid_o) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_timeout"}, (n < 5000), 1'b1);
        chk({tag, "_col"}, col_o, mcol);
        chk({tag, "_rec_cnt"}, rec_cnt_o, mrec);
    endtask

    task automatic chk_tail(input string tag, input string s);
        int base = got.size() - s.len();
        chk({tag, "_tail_len"}, (base >= 0), 1'b1);
        if (base >= 0) begin
            for (int i = 0; i < s.len(); i++) chk($sformatf("%s_tail[%0d]", tag, i), got[base + i], s[i]);
        end
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_stream_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            chk($sformatf("%s_char[%0d]", tag, i), got[i], exp[i]);
        end
        got.delete();
        exp.delete();
    endtask

    initial begin
        int target;
        int n;
        bit seen;
        errors      = 0;
        checks      = 0;
        mcol        = 0;
        mrec        = 0;
        rst_i       = 1'b1;
        txn_valid_i = 1'b0;
        txn_id_i    = '0;
        txn_op_i    = 1'b0;
        txn_addr_i  = '0;
        txn_data_i  = '0;
        flush_i     = 1'b0;
        rand_mode   = 1'b0;
        ready_force = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_ready", txn_ready_o, 1'b0);
        chk("rst_valid", ch_valid_o, 1'b0);
        chk("rst_data", ch_data_o, 8'h00);
        chk("rst_col", col_o, 0);
        chk("rst_rec_cnt", rec_cnt_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", txn_ready_o, 1'b1);

        send(0, 1'b1, 7'h50, 8'h3c, 1'b0);
        wait_done("t1");
        chk_tail("t1", "aa W 50 3c; ");
        cmp_stream("t1");

        send(27, 1'b0, 7'h12, 8'hff, 1'b0);
        wait_done("t2");
        chk_tail("t2", "bb R 12 ff; ");
        cmp_stream("t2");

        do_flush();
        wait_done("flush24");
        chk_tail("flush24", "\n");
        cmp_stream("flush24");

        do_flush();
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ch_valid_o) seen = 1'b1;
        end
        chk("flush0_no_output", seen, 1'b0);
        chk("flush0_col", col_o, 0);
        chk("flush0_ready", txn_ready_o, 1'b1);
        cmp_stream("flush0");

        send(700, 1'b1, 7'h7f, 8'h00, 1'b0);
        wait_done("t3");
        chk_tail("t3", "?y W 7f 00; ");
        cmp_stream("t3");
        do_flush();
        wait_done("flush_t3");
        cmp_stream("flush_t3");

        for (int r = 0; r < 7; r++) begin
            send($urandom_range(0, 1023), 1'($urandom_range(0, 1)), $urandom_range(0, 127),
                 $urandom_range(0, 255), 1'b0);
        end
        wait_done("t4");
        chk("t4_len", got.size(), 85);
        if (got.size() > 72) chk("t4_wrap_nl", got[72], 8'h0a);
        chk("t4_col12", col_o, 12);
        cmp_stream("t4");

        send($urandom_range(0, 1023), 1'b0, $urandom_range(0, 127), $urandom_range(0, 255), 1'b0);
        target = exp.size() - 12 + 4;
        n = 0;
        while (got.size() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_idx4", got.size(), target);
        ready_force = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t5_stall_valid%0d", c), ch_valid_o, 1'b1);
            chk($sformatf("t5_stall_data%0d", c), ch_data_o, 8'h20);
        end
        ready_force = 1'b1;
        wait_done("t5");
        cmp_stream("t5");

        rand_mode = 1'b1;
        for (int r = 0; r < 25; r++) begin
            send($urandom_range(0, 1023), 1'($urandom_range(0, 1)), $urandom_range(0, 127),
                 $urandom_range(0, 255), ($urandom_range(0, 4) == 0));
            wait_done($sformatf("rnd%0d", r));
            cmp_stream($sformatf("rnd%0d", r));
        end
        rand_mode = 1'b0;
        @(negedge clk);

        do_flush();
        wait_done("pre_rst_flush");
        cmp_stream("pre_rst_flush");
        for (int r = 0; r < 6; r++) begin
            send($urandom_range(0, 1023), 1'b1, $urandom_range(0, 127), $urandom_range(0, 255), 1'b0);
        end
        wait_done("fill72");
        chk("fill72_col", col_o, 72);
        cmp_stream("fill72");

        send(53, 1'b0, 7'h21, 8'h9a, 1'b0);
        target = exp.size() - 7;
        n = 0;
        while (got.size() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_idx5", got.size(), target);
        rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_valid", ch_valid_o, 1'b0);
        chk("midrst_data", ch_data_o, 8'h00);
        chk("midrst_col", col_o, 0);
        chk("midrst_rec_cnt", rec_cnt_o, 0);
        chk("midrst_ready", txn_ready_o, 1'b0);
        rst_i = 1'b0;
        got.delete();
        exp.delete();
        mcol = 0;
        mrec = 0;
        @(negedge clk);

        send(1, 1'b1, 7'h0a, 8'hb7, 1'b0);
        wait_done("post_rst");
        chk_tail("post_rst", "ab W 0a b7; ");
        cmp_stream("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/txn_log_formatter.md
Name: txn_log_formatter

Overview:
Converts monitored I2C transfer records into a fixed-format ASCII character stream for the bench log path. Each record carries a transaction ID, op, address and data. The ID is rendered as the two-letter alpha code also used by printing_pkg (j = id div 26, k = id mod 26). Lines wrap at a column limit, matching PRINT_LINE_LEN, and the block sits between the bus monitors and the text sink (console/file writer).

Parameters:
LINE_LEN, 76, max characters per line excluding '\n'; elaboration error if < REC_LEN.
ID_W, 10, transaction ID width.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
txn_valid_i  in  1  record valid
txn_ready_o  out  1  record accepted when valid&ready
txn_id_i  in  ID_W  transaction ID
txn_op_i  in  1  1=write ('W'), 0=read ('R')
txn_addr_i  in  7  I2C address
txn_data_i  in  8  data byte
flush_i  in  1  request line termination
ch_valid_o  out  1  character valid
ch_ready_i  in  1  sink ready
ch_data_o  out  8  ASCII character
col_o  out  7  current column
rec_cnt_o  out  16  records emitted, wraps at 16'hFFFF->0

Behaviour:
- Reset (rst_i high at edge): state IDLE; col_o=0; rec_cnt_o=0; ch_valid_o=0; ch_data_o=8'h00; flush_pend=0. While rst_i is high, txn_ready_o=0.
- Record format, REC_LEN=12 chars: J K ' ' OP ' ' A1 A0 ' ' D1 D0 ';' ' '.
  - Hex digits are lowercase. Address is zero-extended to 8 bits.
  - J='a'+j when j<=25, else '?'. K='a'+k.
- txn_ready_o = (state==IDLE) && !flush_pend && !rst_i. Record fields are captured on the accept edge.
- States:
  - IDLE: if flush_pend, go to FLUSH when col>0, else clear flush_pend and stay. Otherwise, on accept, go to DIVIDE.
  - DIVIDE: each cycle, if rem>=26 then rem-=26 and j++, else exit. Takes exactly floor(id/26)+1 cycles. Exits to WRAP if col+REC_LEN > LINE_LEN, else to EMIT.
  - WRAP: drive '\n'. On handshake, col=0 and go to EMIT.
  - EMIT: drive char[idx], idx 0..11. idx advances on ch_valid&ch_ready. On the final handshake: col+=12, rec_cnt++, return to IDLE.
  - FLUSH: drive '\n'. On handshake: col=0, flush_pend=0, return to IDLE.
- ch_valid_o and ch_data_o are registered. Once valid, they hold stable until a handshake; no character is dropped or duplicated.
  - First character is valid the cycle after DIVIDE/WRAP exit.
  - A new character appears the cycle after each handshake (back-to-back at full throughput).
- flush_i sets flush_pend in any state and is serviced only from IDLE. A record accepted in the same cycle as flush_i completes first, then FLUSH follows.
- Reset mid-operation aborts the record: no partial '\n' is emitted and the next record starts at col 0.
- col_o never exceeds LINE_LEN. With LINE_LEN=76, 6 records fill a line (col 72) and the 7th triggers WRAP.

Decomposition:
- Shared package txn_log_pkg holds:
  - REC_LEN=12.
  - ASCII constants: NL, SP, SEMI, 'W', 'R', '?', 'a', '0'.
  - State enum {IDLE, DIVIDE, WRAP, EMIT, FLUSH}.
  - Function nibble_to_hex.
- One sub-module, alpha_div26: iterative subtract-26 divider with start/done and j/k outputs.
- Character mux and column logic stay in the top level.

Test Plan:
1. id=0, W, addr=7'h50, data=8'h3c, sink always ready -> DIVIDE 1 cycle; stream "aa W 50 3c; "; col_o=12, rec_cnt_o=1.
2. id=27, R, addr=7'h12, data=8'hff -> DIVIDE 2 cycles; stream "bb R 12 ff; ".
3. id=700 (j=26, k=24), W, addr=7'h7f, data=8'h00 -> DIVIDE 27 cycles; stream "?y W 7f 00; ".
4. 7 back-to-back records, sink ready -> 84 record chars plus one '\n' after char 72; col_o=12 at end; rec_cnt_o=7.
5. ch_ready_i low for 5 cycles at record char index 4 -> ch_valid_o=1 and ch_data_o=' ' stable throughout; no loss or duplication.
6. flush_i at col 24 -> single '\n', col_o=0.
   - flush_i at col 0 -> no output.
   - rst_i at EMIT idx 5 -> ch_valid_o=0 next cycle, col_o=0, rec_cnt_o=0; next record is emitted without a leading '\n'.
